i2c_temp_target: RTL

// I2C target (responder) emulating one two-byte temperature sensor: the far end of our I2C temperature-read master.

---
 rtl/i2c_temp_target_if.sv | 11 +
 rtl/i2c_temp_target.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_temp_target_if.sv
// rtl/i2c_temp_target_if.sv - I2C pin bundle between a bus master and the temperature target
// Ports: scl_in, sda_in  raw pin levels seen by the target
//        sda_oe          target open-drain pull-down request (1 = drive SDA low)
interface i2c_temp_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_temp_target.sv
// rtl/i2c_temp_target.sv - I2C target emulating a two-byte temperature sensor
// Ports: clk25 25 MHz clock; reset sync active-high
//        bus.scl_in/bus.sda_in raw pins (async), bus.sda_oe open-drain pull-down
//        temp_msb/temp_lsb bytes served on reads; pointer last written byte
//        busy transfer addressed to us; wr_strobe pointer update pulse;
//        rd_done pulse when the master NACKs a read byte
module i2c_temp_target #(
  parameter logic [6:0] DEV_ADDR = 7'h49,
  parameter int         HOLD_CYC = 8
) (
  input  logic                    clk25,
  input  logic                    reset,
  i2c_temp_target_if.slave        bus,
  input  logic [7:0]              temp_msb,
  input  logic [7:0]              temp_lsb,
  output logic [7:0]              pointer,
  output logic                    busy,
  output logic                    wr_strobe,
  output logic                    rd_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_h;
  logic        sda_s1, sda_s2, sda_h;
  logic [3:0]  bitcnt;
  logic [6:0]  shreg;
  logic [15:0] shadow;
  logic        byte_idx;
  logic        first_byte;
  logic        rw;
  logic [7:0]  hold_cnt;

  logic        scl_rise, scl_fall, start_det, stop_det, fire;
  logic [7:0]  byte_in, cur_byte;
  logic        rd_bit;

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
  // Every SDA change is deferred to this point, HOLD_CYC cycles after SCL fall.
  assign fire      = (hold_cnt == 8'd1);
  assign byte_in   = {shreg, sda_s2};
  assign cur_byte  = byte_idx ? shadow[7:0] : shadow[15:8];
  // Bits go out MSB first: bit index 7 - bitcnt.
  assign rd_bit    = cur_byte[~bitcnt[2:0]];

  always_ff @(posedge clk25) begin
    if (reset) begin
      scl_s1     <= 1'b1;
      scl_s2     <= 1'b1;
      scl_h      <= 1'b1;
      sda_s1     <= 1'b1;
      sda_s2     <= 1'b1;
      sda_h      <= 1'b1;
      state      <= IDLE;
      bitcnt     <= 4'd0;
      shreg      <= 7'd0;
      shadow     <= 16'd0;
      byte_idx   <= 1'b0;
      first_byte <= 1'b0;
      rw         <= 1'b0;
      hold_cnt   <= 8'd0;
      bus.sda_oe <= 1'b0;
      pointer    <= 8'h00;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      rd_done    <= 1'b0;
    end else begin
      scl_s1    <= bus.scl_in;
      scl_s2    <= scl_s1;
      scl_h     <= scl_s2;
      sda_s1    <= bus.sda_in;
      sda_s2    <= sda_s1;
      sda_h     <= sda_s2;
      wr_strobe <= 1'b0;
      rd_done   <= 1'b0;

      if (scl_fall) begin
        hold_cnt <= 8'(HOLD_CYC);
      end else if (hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end

      // Bus conditions override any SCL activity in the same cycle.
      if (start_det) begin
        state      <= ADDR;
        bitcnt     <= 4'd0;
        bus.sda_oe <= 1'b0;
        hold_cnt   <= 8'd0;
      end else if (stop_det) begin
        state      <= IDLE;
        bitcnt     <= 4'd0;
        bus.sda_oe <= 1'b0;
        busy       <= 1'b0;
        hold_cnt   <= 8'd0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg  <= byte_in[6:0];
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state      <= ADDR_ACK;
                  busy       <= 1'b1;
                  rw         <= byte_in[0];
                  // Capture both bytes together so a read never mixes two samples.
                  shadow     <= {temp_msb, temp_lsb};
                  byte_idx   <= 1'b0;
                  first_byte <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                  busy  <= 1'b0;
                end
              end
            end
          end

          // bitcnt is 8 on entry: the first deferred fall drives ACK, the 9th rise
          // bumps it to 9, and the following deferred fall ends the ACK slot.
          ADDR_ACK, WR_ACK: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (fire) begin
              if (bitcnt == 4'd8) begin
                bus.sda_oe <= 1'b1;
              end else if (bitcnt == 4'd9) begin
                bitcnt <= 4'd0;
                if (state == ADDR_ACK && rw) begin
                  state      <= RD_BYTE;
                  bus.sda_oe <= ~shadow[15];
                end else begin
                  state      <= WR_BYTE;
                  bus.sda_oe <= 1'b0;
                end
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shreg  <= byte_in[6:0];
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                state <= WR_ACK;
                if (first_byte) begin
                  pointer    <= byte_in;
                  wr_strobe  <= 1'b1;
                  first_byte <= 1'b0;
                end
              end
            end
          end

          RD_BYTE: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 4'd1;
            end else if (fire) begin
              if (bitcnt == 4'd8) begin
                bus.sda_oe <= 1'b0;
                state      <= RD_ACK;
              end else begin
                bus.sda_oe <= ~rd_bit;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state   <= WAIT_STOP;
                rd_done <= 1'b1;
                busy    <= 1'b0;
              end else begin
                // Next byte's MSB goes out on the fall that ends this ACK.
                state    <= RD_BYTE;
                bitcnt   <= 4'd0;
                byte_idx <= ~byte_idx;
              end
            end
          end

          IDLE, WAIT_STOP: begin
            bus.sda_oe <= 1'b0;
          end

          default: begin
            state      <= IDLE;
            bus.sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
